inst_prefetch_sram_like: RTL
============================

// Module: inst_prefetch_sram_like
// PURPOSE
//  Instruction-fetch bridge between the IF stage and the sram-like inst port, successor to the single-request fetch bridge.
//  Runs ahead sequentially (PC, PC+4, ...) with up to MAX_OUTSTANDING in-flight reads and buffers words in a FIFO_DEPTH FIFO.
//  On flush it drains stale in-flight responses without stalling new fetches, then restarts at flush_addr_i.
// PARAMETERS
//  FIFO_DEPTH       4             response FIFO entries; power of two, >=2
//  MAX_OUTSTANDING  2             max addr_ok-accepted reads awaiting data_ok; 1..FIFO_DEPTH
//  STALL_W          5             width of stall_i
//  RESET_PC         32'hBFC00000  first fetch address after reset
// PORTS
//  clock          in   1        clock
//  reset          in   1        asynchronous, active-low reset
//  stall_i        in   STALL_W  pipeline stall vector; any bit set = IF word not consumed
//  flush_i        in   1        redirect/flush, single-cycle pulse
//  flush_addr_i   in   32       new fetch PC, valid with flush_i
//  cpu_data_o     out  32       instruction at FIFO head (0 when invalid)
//  cpu_pc_o       out  32       PC of cpu_data_o (0 when invalid)
//  cpu_valid_o    out  1        head word valid
//  stallreq       out  1        = !cpu_valid_o
//  inst_req       out  1        sram-like request
//  inst_wr/inst_size/inst_wdata out 1/2/32  constant 0 / 2'b10 / 0
//  inst_addr      out  32       request address
//  inst_cache     out  1        0 if inst_addr[31:29]==3'b101 (kseg1), else 1
//  inst_rdata     in   32       read data
//  inst_addr_ok   in   1        request accepted
//  inst_data_ok   in   1        data returned, in request order
// BEHAVIOUR
//  Reset: inst_req=0, inst_addr=0, inst_cache=0, cpu_valid_o=0, stallreq=1, cpu_data_o=0, cpu_pc_o=0; fetch_pc=RESET_PC; counters and FIFO empty.
//  State: fetch_pc, O (outstanding, incl. stale), D (stale to drop), F (FIFO count), pend (req held awaiting addr_ok), pend_stale.
//  Issue: when !pend and O<MAX_OUTSTANDING and F+(O-D)<FIFO_DEPTH (reserved slot per live read), register inst_req=1,
//   inst_addr=fetch_pc, inst_cache per kseg1 rule; pend=1. First req appears the cycle after reset release.
//  inst_req/inst_addr/inst_cache stay stable while pend until inst_addr_ok; on addr_ok: O+=1, fetch_pc+=4, inst_req=0 next cycle
//   unless a new issue is registered the same edge (back-to-back allowed; inst_addr becomes next PC).
//  Return: on inst_data_ok, O-=1; if D>0 then D-=1 and word discarded, else {fetch PC of that read, inst_rdata} pushed to FIFO.
//   FIFO never overflows (credit rule); data_ok with O==0 is a protocol error (assert in sim, ignore in RTL).
//  Output: cpu_valid_o = (F!=0) && !flush_i; head visible the cycle after data_ok (1-cycle latency, no bypass).
//   Pop when cpu_valid_o && stall_i==0; pop and push same cycle keep F constant.
//  Flush (flush_i=1): FIFO cleared; D <= O after this cycle's addr_ok/data_ok updates (all live reads become stale);
//   fetch_pc <= flush_addr_i. If pend and no addr_ok this cycle: request held unchanged, pend_stale=1; its later addr_ok
//   increments O and D together and leaves fetch_pc at flush_addr_i. If addr_ok coincides with flush, that read is stale.
//  After flush new requests may issue immediately subject to O<MAX_OUTSTANDING; stale responses always drain first (in order).
//  Flush while stall_i!=0: still clears; head word is not popped.
//  Back-to-back flushes: each re-counts D from current O; last flush_addr_i wins.
//  Widths: O, D count to MAX_OUTSTANDING, F to FIFO_DEPTH, sized $clog2(N+1); PC wraps modulo 2^32.
//  Reset mid-transaction: all state cleared asynchronously; responses from pre-reset reads are not expected (bus resets too).
// TESTING
//  1 Reset, addr_ok/data_ok every cycle, stall_i=0 -> inst_addr BFC00000,BFC00004,...; cpu_pc_o streams same, valid 1 cycle after data_ok.
//  2 stall_i=5'b00010 for 10 cycles, memory always ready -> exactly FIFO_DEPTH words buffered, inst_req deasserts, cpu_data_o held.
//  3 Two reads outstanding (data_ok withheld), flush_i with flush_addr_i=80001000 -> next 2 data_ok discarded, first valid cpu_pc_o=80001000.
//  4 inst_req pending without addr_ok, flush -> inst_addr unchanged until addr_ok, that response dropped, next req addr=flush_addr_i.
//  5 flush same cycle as addr_ok and data_ok -> D equals O after edge; no stale word ever reaches cpu_valid_o.
//  6 Fetch at A0000000 -> inst_cache=0; at 9FC00000 -> inst_cache=1; async reset mid-stream -> outputs to reset values immediately.

Source files
------------

// File: rtl/inst_prefetch_sram_like.sv
// Sequential instruction prefetcher for an sram-like inst port: several reads in flight,
// a response FIFO toward IF, and flush handling that drops stale responses in order.
module inst_prefetch_sram_like #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_W         = 5,
  parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_addr_i,
  output logic [31:0]        cpu_data_o,
  output logic [31:0]        cpu_pc_o,
  output logic               cpu_valid_o,
  output logic               stallreq,
  output logic               inst_req,
  output logic               inst_wr,
  output logic [1:0]         inst_size,
  output logic [31:0]        inst_wdata,
  output logic [31:0]        inst_addr,
  output logic               inst_cache,
  input  logic [31:0]        inst_rdata,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] stale_q, stale_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pend_stale_q, pend_stale_d;
  logic [31:0]   addr_q, addr_d;
  logic          cache_q, cache_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [31:0]   pcq [MAX_OUTSTANDING];

  logic addr_acc, resp, drop, push, pop, pend_hold, issue;
  int   out_n, stale_n, cnt_n, widx;

  assign cpu_valid_o = (cnt_q != '0) && !flush_i;
  assign stallreq    = !cpu_valid_o;
  assign cpu_data_o  = cpu_valid_o ? fifo_mem[rptr_q][31:0] : '0;
  assign cpu_pc_o    = cpu_valid_o ? fifo_mem[rptr_q][63:32] : '0;
  assign inst_req    = pend_q;
  assign inst_addr   = addr_q;
  assign inst_cache  = cache_q;
  assign inst_wr     = 1'b0;
  assign inst_size   = 2'b10;
  assign inst_wdata  = '0;

  always_comb begin
    addr_acc = pend_q && inst_addr_ok;
    resp     = inst_data_ok && (out_q != '0);
    drop     = resp && (stale_q != '0);
    push     = resp && !drop && !flush_i;
    pop      = cpu_valid_o && (stall_i == '0);
    widx     = int'(out_q) - int'(resp);
    out_n    = int'(out_q) + int'(addr_acc) - int'(resp);
    stale_n  = int'(stale_q) - int'(drop) + int'(addr_acc && pend_stale_q);
    cnt_n    = int'(cnt_q) + int'(push) - int'(pop);
    fetch_pc_d = fetch_pc_q;
    // A read requested before a flush must not advance the redirected PC.
    if (addr_acc && !pend_stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
    if (flush_i) begin
      cnt_n      = 0;
      stale_n    = out_n;
      fetch_pc_d = flush_addr_i;
    end
    pend_hold = pend_q && !addr_acc;
    // Each live read reserves a FIFO slot so returning data can never overflow.
    issue = !pend_hold && (out_n < int'(MAX_OUTSTANDING)) &&
            (cnt_n + out_n - stale_n < int'(FIFO_DEPTH));
    pend_d       = pend_hold || issue;
    pend_stale_d = pend_hold && (pend_stale_q || flush_i);
    addr_d       = issue ? fetch_pc_d : addr_q;
    cache_d      = issue ? (fetch_pc_d[31:29] != 3'b101) : cache_q;
    out_d        = OW'(out_n);
    stale_d      = OW'(stale_n);
    cnt_d        = FW'(cnt_n);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      out_q        <= '0;
      stale_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_stale_q <= 1'b0;
      addr_q       <= '0;
      cache_q      <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      out_q        <= out_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_stale_q <= pend_stale_d;
      addr_q       <= addr_d;
      cache_q      <= cache_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_q + PW'(push);
        rptr_q <= rptr_q + PW'(pop);
      end
    end
  end

  // Storage needs no reset: visibility is governed by the counters above.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr_q] <= {pcq[0], inst_rdata};
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (addr_acc && i == widx) pcq[i] <= addr_q;
      else if (resp && i < int'(MAX_OUTSTANDING) - 1)
        pcq[i] <= pcq[(i + 1) % int'(MAX_OUTSTANDING)];
    end
  end

  a_no_spurious_data_ok: assert property (@(posedge clock) disable iff (!reset)
    inst_data_ok |-> out_q != '0);

endmodule
